// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the fetch hazard controller: FSM states, load-use counter width,
// and the classification of a branch resolving in EX.
package fetch_ctrl_pkg;

    localparam int LU_CNT_W      = 3;
    localparam int REG_W_DEFAULT = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FREEZE   = 2'd2
    } fetch_state_e;

    // MP_NOT_TAKEN: predicted taken, resolved not taken.
    // MP_TAKEN_*:   predicted not taken, resolved taken; suffix is the EX-side BTB hit.
    typedef enum logic [1:0] {
        MP_NONE       = 2'd0,
        MP_NOT_TAKEN  = 2'd1,
        MP_TAKEN_HIT  = 2'd2,
        MP_TAKEN_MISS = 2'd3
    } mp_kind_e;

    function automatic logic is_redirect(input mp_kind_e kind);
        return kind != MP_NONE;
    endfunction

endpackage

// File: rtl/branch_resolve_decode.sv
// Classifies the branch resolving in EX against its IF-time prediction and BTB hit.
module branch_resolve_decode
    import fetch_ctrl_pkg::*;
(
    input  logic     branch_E,
    input  logic     bne_E,
    input  logic     real_Value_E,
    input  logic     prediction_E,
    input  logic     hit_E,
    output logic     br_E,
    output mp_kind_e mp_kind
);

    logic pred_tk;

    always_comb begin
        br_E    = branch_E | bne_E;
        pred_tk = prediction_E & hit_E;
        mp_kind = MP_NONE;
        if (br_E) begin
            if (pred_tk && !real_Value_E) begin
                mp_kind = MP_NOT_TAKEN;
            end else if (!pred_tk && real_Value_E) begin
                mp_kind = hit_E ? MP_TAKEN_HIT : MP_TAKEN_MISS;
            end
        end
    end

endmodule

// File: rtl/fetch_hazard_controller.sv
// Fetch-stage hazard sequencer: branch mispredict recovery, JR bubble, load-use stalls, memory freeze.
// Optional performance counters are built when FETCH_CTRL_PERF_EN is defined.
//
//  state    | meaning
//  ---------+----------------------------------------------------------------
//  RUN      | normal fetch; load-use detection active
//  LU_STALL | holding PC/IF-ID for the remaining load-use bubbles
//  FREEZE   | ext_stall asserted; prior state and bubble count held
module fetch_hazard_controller
    import fetch_ctrl_pkg::*;
#(
    parameter int LU_STALL_CYCLES = 1,
    parameter int REG_W           = REG_W_DEFAULT,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ext_stall,
    input  logic             branch_E,
    input  logic             bne_E,
    input  logic             real_Value_E,
    input  logic             prediction_E,
    input  logic             hit_E,
    input  logic             flush_JR,
    input  logic             memRead_E,
    input  logic [REG_W-1:0] rt_E,
    input  logic [REG_W-1:0] rs_D,
    input  logic [REG_W-1:0] rt_D,
    output logic             PC_WRite,
    output logic             IF_ID_write,
    output logic             ID_EX_flush,
    output logic             flush,
    output logic             flush_hit,
    output logic             selectCorrectTarget,
    output logic             selectCorrectPcPlus1,
    output logic             select_hit
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] mispredict_cnt,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    localparam logic [LU_CNT_W-1:0] LU_LAST = LU_CNT_W'(LU_STALL_CYCLES - 1);

    fetch_state_e          state, next_state;
    fetch_state_e          saved_state, next_saved;
    fetch_state_e          eff_state;
    logic [LU_CNT_W-1:0]   lu_cnt, next_cnt;
    logic                  br_E;
    logic                  load_use;
    mp_kind_e              mp_kind;

    branch_resolve_decode u_resolve (
        .branch_E     (branch_E),
        .bne_E        (bne_E),
        .real_Value_E (real_Value_E),
        .prediction_E (prediction_E),
        .hit_E        (hit_E),
        .br_E         (br_E),
        .mp_kind      (mp_kind)
    );

    // Leaving FREEZE behaves as the saved state in the same cycle ext_stall drops.
    always_comb begin
        eff_state  = (state == FREEZE) ? saved_state : state;
        load_use   = memRead_E && (rt_E != '0) && ((rt_E == rs_D) || (rt_E == rt_D));
        next_state = eff_state;
        next_saved = saved_state;
        next_cnt   = lu_cnt;

        PC_WRite             = 1'b1;
        IF_ID_write          = 1'b1;
        ID_EX_flush          = 1'b0;
        flush                = 1'b0;
        flush_hit            = 1'b0;
        selectCorrectTarget  = 1'b0;
        selectCorrectPcPlus1 = 1'b0;
        select_hit           = 1'b0;

        if (ext_stall) begin
            PC_WRite    = 1'b0;
            IF_ID_write = 1'b0;
            next_state  = FREEZE;
            next_saved  = eff_state;
        end else if (is_redirect(mp_kind)) begin
            ID_EX_flush          = 1'b1;
            flush                = (mp_kind != MP_TAKEN_MISS);
            flush_hit            = (mp_kind == MP_TAKEN_MISS);
            selectCorrectTarget  = (mp_kind == MP_TAKEN_HIT);
            selectCorrectPcPlus1 = (mp_kind == MP_NOT_TAKEN);
            select_hit           = (mp_kind != MP_NOT_TAKEN);
            next_state           = RUN;
            next_cnt             = '0;
        end else if (flush_JR) begin
            ID_EX_flush = 1'b1;
            next_state  = RUN;
            next_cnt    = '0;
        end else if (eff_state == LU_STALL) begin
            PC_WRite    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
            if (lu_cnt == LU_LAST) begin
                next_state = RUN;
                next_cnt   = '0;
            end else begin
                next_cnt = lu_cnt + LU_CNT_W'(1);
            end
        end else if (load_use) begin
            PC_WRite    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
            if (LU_STALL_CYCLES > 1) begin
                next_state = LU_STALL;
                next_cnt   = LU_CNT_W'(1);
            end
        end

        if (reset) begin
            PC_WRite             = 1'b1;
            IF_ID_write          = 1'b1;
            ID_EX_flush          = 1'b0;
            flush                = 1'b0;
            flush_hit            = 1'b0;
            selectCorrectTarget  = 1'b0;
            selectCorrectPcPlus1 = 1'b0;
            select_hit           = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            saved_state <= RUN;
            lu_cnt      <= '0;
        end else begin
            state       <= next_state;
            saved_state <= next_saved;
            lu_cnt      <= next_cnt;
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic br_inc, mp_inc, stall_inc;

    assign br_inc    = !ext_stall && br_E;
    assign mp_inc    = !ext_stall && is_redirect(mp_kind);
    assign stall_inc = !PC_WRite;

    // Saturating counters; all-ones is sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
            stall_cnt      <= '0;
        end else begin
            if (br_inc && (branch_cnt != '1)) begin
                branch_cnt <= branch_cnt + CNT_W'(1);
            end
            if (mp_inc && (mispredict_cnt != '1)) begin
                mispredict_cnt <= mispredict_cnt + CNT_W'(1);
            end
            if (stall_inc && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end
`else
    logic [CNT_W-1:0] perf_unused;
    assign perf_unused = '0;
`endif

endmodule
